// File: rtl/vmicro16_intc_apb_pkg.sv
// vmicro16_intc_apb_pkg
//   Shared configuration for the APB interrupt controller: SoC-level
//   defaults (bus widths, interrupt count, APB select slot) and the
//   controller register map.
package vmicro16_intc_apb_pkg;

    // SoC-wide defaults
    localparam int unsigned DEF_APB_WIDTH   = 16;
    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_NUM_INT     = 8;
    localparam int unsigned DEF_INT_TIMR0   = 0;

    // APB select slot occupied by interrupt controller 0
    localparam int unsigned APB_PSELX_INTC0 = 10;

    // Register offsets, decoded from PADDR[1:0]
    typedef enum logic [1:0] {
        INTC_PEND = 2'd0,
        INTC_MASK = 2'd1,
        INTC_VEC  = 2'd2,
        INTC_CTRL = 2'd3
    } intc_reg_e;

    // Bit position of the irq flag inside the VEC register
    localparam int unsigned INTC_VEC_IRQ_BIT = 15;

    // Width of an index into n lines, never less than one bit
    function automatic int unsigned vec_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vmicro16_prio_enc.sv
// vmicro16_prio_enc
//   Lowest-index-first priority encoder, purely combinational.
//   req   : request vector, bit 0 has the highest priority
//   valid : at least one request is set
//   index : index of the winning request (0 when valid is low)
module vmicro16_prio_enc #(
    parameter int unsigned NUM_INT  = 8,
    parameter int unsigned VEC_BITS = 3
) (
    input  logic [NUM_INT-1:0]  req,
    output logic                valid,
    output logic [VEC_BITS-1:0] index
);

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < NUM_INT; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                index = VEC_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/vmicro16_intc_apb.sv
// vmicro16_intc_apb
//   APB slave interrupt controller. Level interrupt sources are edge
//   detected into pending bits, masked per line and gated by a global
//   enable; the lowest-indexed active line is presented to the cores as
//   irq/irq_vec/irq_data and cleared by a single-cycle irq_ack.
//
//   Ports:
//     clk, reset        system clock, synchronous active-high reset
//     S_P*              APB slave (zero wait states), PADDR[1:0] decoded
//                       0 PEND (W1C), 1 MASK, 2 VEC (ro), 3 CTRL
//     ints, ints_data   level sources and per-line payloads
//     irq, irq_vec,     registered request, winning line and its payload
//     irq_data
//     irq_ack           acknowledge, clears the pending bit of irq_vec
module vmicro16_intc_apb
    import vmicro16_intc_apb_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = DEF_APB_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_INT    = DEF_NUM_INT,
    parameter int unsigned VEC_BITS   = vec_bits(NUM_INT)
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [BUS_WIDTH-1:0]          S_PADDR,
    input  logic                          S_PWRITE,
    input  logic                          S_PSELx,
    input  logic                          S_PENABLE,
    input  logic [DATA_WIDTH-1:0]         S_PWDATA,
    output logic [DATA_WIDTH-1:0]         S_PRDATA,
    output logic                          S_PREADY,

    input  logic [NUM_INT-1:0]            ints,
    input  logic [NUM_INT*DATA_WIDTH-1:0] ints_data,

    output logic                          irq,
    output logic [VEC_BITS-1:0]           irq_vec,
    output logic [DATA_WIDTH-1:0]         irq_data,
    input  logic                          irq_ack
);

    // State
    logic [NUM_INT-1:0]    ints_q,  ints_d;
    logic [NUM_INT-1:0]    pend_q,  pend_d;
    logic [NUM_INT-1:0]    mask_q,  mask_d;
    logic                  ctrl_q,  ctrl_d;
    logic [DATA_WIDTH-1:0] data_q [NUM_INT];
    logic [DATA_WIDTH-1:0] data_d [NUM_INT];
    logic                  irq_q,      irq_d;
    logic [VEC_BITS-1:0]   irq_vec_q,  irq_vec_d;
    logic [DATA_WIDTH-1:0] irq_data_q, irq_data_d;

    // Combinational helpers
    logic                  apb_acc;
    logic                  apb_wr;
    intc_reg_e             reg_sel;
    logic [NUM_INT-1:0]    rise;
    logic [NUM_INT-1:0]    ack_oh;
    logic [NUM_INT-1:0]    clr;
    logic [NUM_INT-1:0]    active;
    logic                  win_valid;
    logic [VEC_BITS-1:0]   win_idx;

    // Only PADDR[1:0] and the low PWDATA bits are decoded
    logic                  unused_bits;
    assign unused_bits = ^{S_PADDR, S_PWDATA};

    assign apb_acc  = S_PSELx & S_PENABLE;
    assign apb_wr   = apb_acc & S_PWRITE;
    assign reg_sel  = intc_reg_e'(S_PADDR[1:0]);
    assign S_PREADY = apb_acc;

    assign rise   = ints & ~ints_q;
    assign active = pend_q & mask_q & {NUM_INT{ctrl_q}};

    vmicro16_prio_enc #(
        .NUM_INT  (NUM_INT),
        .VEC_BITS (VEC_BITS)
    ) u_prio_enc (
        .req   (active),
        .valid (win_valid),
        .index (win_idx)
    );

    // One-hot of the line currently being presented, used by irq_ack
    always_comb begin
        ack_oh = '0;
        for (int unsigned i = 0; i < NUM_INT; i++) begin
            ack_oh[i] = (irq_vec_q == VEC_BITS'(i));
        end
    end

    // Clear sources: software W1C on PEND and core acknowledge
    always_comb begin
        clr = '0;
        if (apb_wr && reg_sel == INTC_PEND) begin
            clr = S_PWDATA[NUM_INT-1:0];
        end
        if (irq_ack && irq_q) begin
            clr = clr | ack_oh;
        end
    end

    // Next-state logic; a rise wins over a clear in the same cycle
    always_comb begin
        ints_d = ints;
        pend_d = (pend_q & ~clr) | rise;
        mask_d = mask_q;
        ctrl_d = ctrl_q;

        if (apb_wr && reg_sel == INTC_MASK) begin
            mask_d = S_PWDATA[NUM_INT-1:0];
        end
        if (apb_wr && reg_sel == INTC_CTRL) begin
            ctrl_d = S_PWDATA[0];
        end

        for (int unsigned i = 0; i < NUM_INT; i++) begin
            data_d[i] = rise[i] ? ints_data[i*DATA_WIDTH +: DATA_WIDTH] : data_q[i];
        end

        // Vector and payload hold their last value when nothing is active
        irq_d      = win_valid;
        irq_vec_d  = win_valid ? win_idx : irq_vec_q;
        irq_data_d = win_valid ? data_q[win_idx] : irq_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ints_q     <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
            ctrl_q     <= 1'b0;
            irq_q      <= 1'b0;
            irq_vec_q  <= '0;
            irq_data_q <= '0;
            for (int unsigned i = 0; i < NUM_INT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            ints_q     <= ints_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            ctrl_q     <= ctrl_d;
            irq_q      <= irq_d;
            irq_vec_q  <= irq_vec_d;
            irq_data_q <= irq_data_d;
            for (int unsigned i = 0; i < NUM_INT; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Read mux reflects current register state, before this edge's update
    always_comb begin
        S_PRDATA = '0;
        if (apb_acc) begin
            unique case (reg_sel)
                INTC_PEND: S_PRDATA[NUM_INT-1:0] = pend_q;
                INTC_MASK: S_PRDATA[NUM_INT-1:0] = mask_q;
                INTC_VEC: begin
                    S_PRDATA[INTC_VEC_IRQ_BIT] = irq_q;
                    S_PRDATA[VEC_BITS-1:0]     = irq_vec_q;
                end
                INTC_CTRL: S_PRDATA[0] = ctrl_q;
            endcase
        end
    end

    assign irq      = irq_q;
    assign irq_vec  = irq_vec_q;
    assign irq_data = irq_data_q;

endmodule

// File: tb/tb_vmicro16_intc_apb.sv
module tb_vmicro16_intc_apb;

    localparam int unsigned BW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned NI  = 8;
    localparam int unsigned VB  = 3;

    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_VEC  = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [BW-1:0]     paddr = '0;
    logic              pwrite = 1'b0;
    logic              psel = 1'b0;
    logic              penable = 1'b0;
    logic [DW-1:0]     pwdata = '0;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic [NI-1:0]     ints = '0;
    logic [NI*DW-1:0]  ints_data = '0;
    logic              irq;
    logic [VB-1:0]     irq_vec;
    logic [DW-1:0]     irq_data;
    logic              irq_ack = 1'b0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    vmicro16_intc_apb #(
        .BUS_WIDTH  (BW),
        .DATA_WIDTH (DW),
        .NUM_INT    (NI),
        .VEC_BITS   (VB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .S_PADDR   (paddr),
        .S_PWRITE  (pwrite),
        .S_PSELx   (psel),
        .S_PENABLE (penable),
        .S_PWDATA  (pwdata),
        .S_PRDATA  (prdata),
        .S_PREADY  (pready),
        .ints      (ints),
        .ints_data (ints_data),
        .irq       (irq),
        .irq_vec   (irq_vec),
        .irq_data  (irq_data),
        .irq_ack   (irq_ack)
    );

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Setup phase then access phase; the write lands on the access edge
    task automatic apb_write(input logic [1:0] a, input logic [DW-1:0] d);
        paddr = BW'(a); pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Combinational read between edges, consumes no clock
    task automatic apb_read(input logic [1:0] a, output logic [DW-1:0] d);
        paddr = BW'(a); pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
        #1;
        d = prdata;
        psel = 1'b0; penable = 1'b0;
        #1;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] r;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else passed++;
        total++; if (irq_vec !== 3'd0) $display("FAIL reset_vec: got %h want 0", irq_vec); else passed++;
        total++; if (irq_data !== 16'h0) $display("FAIL reset_data: got %h want 0000", irq_data); else passed++;
        apb_read(A_PEND, r);
        total++; if (r !== 16'h0) $display("FAIL reset_pend: got %h want 0000", r); else passed++;
        apb_read(A_MASK, r);
        total++; if (r !== 16'h0) $display("FAIL reset_mask: got %h want 0000", r); else passed++;
        apb_read(A_CTRL, r);
        total++; if (r !== 16'h0) $display("FAIL reset_ctrl: got %h want 0000", r); else passed++;
        total++; if (prdata !== 16'h0) $display("FAIL idle_prdata: got %h want 0000", prdata); else passed++;
    endtask

    task automatic test_regs();
        logic [DW-1:0] r;
        apb_write(A_MASK, 16'hFFFF);
        apb_read(A_MASK, r);
        total++; if (r !== 16'h00FF) $display("FAIL mask_upper_bits: got %h want 00ff", r); else passed++;
        apb_write(A_CTRL, 16'hFFFF);
        apb_read(A_CTRL, r);
        total++; if (r !== 16'h0001) $display("FAIL ctrl_upper_bits: got %h want 0001", r); else passed++;
        apb_write(A_CTRL, 16'h0000);
        apb_write(A_MASK, 16'h0000);
        apb_read(A_MASK, r);
        total++; if (r !== 16'h0000) $display("FAIL mask_clear: got %h want 0000", r); else passed++;
    endtask

    task automatic test_single();
        logic [DW-1:0] r;
        apb_write(A_MASK, 16'h0001);
        apb_write(A_CTRL, 16'h0001);
        ints_data[0*DW +: DW] = 16'h1234;
        ints[0] = 1'b1;
        tick();                                  // edge k: pend set
        total++; if (irq !== 1'b0) $display("FAIL single_irq_early: got %b want 0", irq); else passed++;
        apb_read(A_PEND, r);
        total++; if (r !== 16'h0001) $display("FAIL single_pend: got %h want 0001", r); else passed++;
        tick();                                  // edge k+1: irq up
        total++; if (irq !== 1'b1) $display("FAIL single_irq: got %b want 1", irq); else passed++;
        total++; if (irq_vec !== 3'd0) $display("FAIL single_vec: got %h want 0", irq_vec); else passed++;
        total++; if (irq_data !== 16'h1234) $display("FAIL single_data: got %h want 1234", irq_data); else passed++;
        tick();
        ints[0] = 1'b0;
        apb_read(A_PEND, r);
        total++; if (r !== 16'h0001) $display("FAIL single_pend_held: got %h want 0001", r); else passed++;
        pulse_ack();
        apb_read(A_PEND, r);
        total++; if (r !== 16'h0000) $display("FAIL ack_pend: got %h want 0000", r); else passed++;
        tick();
        total++; if (irq !== 1'b0) $display("FAIL ack_irq: got %b want 0", irq); else passed++;
        pulse_ack();                             // ack while irq=0
        tick();
        apb_read(A_PEND, r);
        total++; if (r !== 16'h0000) $display("FAIL idle_ack_pend: got %h want 0000", r); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL idle_ack_irq: got %b want 0", irq); else passed++;
        total++; if (irq_data !== 16'h1234) $display("FAIL idle_hold_data: got %h want 1234", irq_data); else passed++;
    endtask

    task automatic test_priority();
        logic [DW-1:0] r;
        apb_write(A_MASK, 16'h0003);
        ints_data[0*DW +: DW] = 16'hAAAA;
        ints_data[1*DW +: DW] = 16'hBBBB;
        ints[1:0] = 2'b11;
        tick();
        tick();
        ints[1:0] = 2'b00;
        total++; if (irq !== 1'b1) $display("FAIL prio_irq: got %b want 1", irq); else passed++;
        total++; if (irq_vec !== 3'd0) $display("FAIL prio_vec0: got %h want 0", irq_vec); else passed++;
        total++; if (irq_data !== 16'hAAAA) $display("FAIL prio_data0: got %h want aaaa", irq_data); else passed++;
        pulse_ack();
        apb_read(A_PEND, r);
        total++; if (r !== 16'h0002) $display("FAIL prio_pend_after_ack: got %h want 0002", r); else passed++;
        tick();
        total++; if (irq_vec !== 3'd1) $display("FAIL prio_vec1: got %h want 1", irq_vec); else passed++;
        total++; if (irq_data !== 16'hBBBB) $display("FAIL prio_data1: got %h want bbbb", irq_data); else passed++;
        total++; if (irq !== 1'b1) $display("FAIL prio_irq1: got %b want 1", irq); else passed++;
        pulse_ack();
        tick();
        total++; if (irq !== 1'b0) $display("FAIL prio_irq_done: got %b want 0", irq); else passed++;
    endtask

    task automatic test_mask();
        logic [DW-1:0] r;
        apb_write(A_MASK, 16'h0000);
        ints_data[1*DW +: DW] = 16'h5555;
        ints[1] = 1'b1;
        tick();
        ints[1] = 1'b0;
        tick(); tick();
        total++; if (irq !== 1'b0) $display("FAIL masked_irq: got %b want 0", irq); else passed++;
        apb_read(A_PEND, r);
        total++; if (r !== 16'h0002) $display("FAIL masked_pend: got %h want 0002", r); else passed++;
        apb_write(A_MASK, 16'h0002);
        total++; if (irq !== 1'b0) $display("FAIL unmask_irq_early: got %b want 0", irq); else passed++;
        tick();
        total++; if (irq !== 1'b1) $display("FAIL unmask_irq: got %b want 1", irq); else passed++;
        total++; if (irq_data !== 16'h5555) $display("FAIL unmask_data: got %h want 5555", irq_data); else passed++;
        apb_read(A_VEC, r);
        total++; if (r !== 16'h8001) $display("FAIL vec_reg: got %h want 8001", r); else passed++;
        apb_write(A_CTRL, 16'h0000);
        tick();
        total++; if (irq !== 1'b0) $display("FAIL disable_irq: got %b want 0", irq); else passed++;
        apb_read(A_PEND, r);
        total++; if (r !== 16'h0002) $display("FAIL disable_keeps_pend: got %h want 0002", r); else passed++;
        apb_write(A_CTRL, 16'h0001);
        tick();
        pulse_ack();
        tick();
        apb_read(A_PEND, r);
        total++; if (r !== 16'h0000) $display("FAIL mask_cleanup_pend: got %h want 0000", r); else passed++;
    endtask

    task automatic test_w1c_vs_rise();
        logic [DW-1:0] r;
        ints[0] = 1'b1;
        tick();
        ints[0] = 1'b0;
        tick();
        apb_write(A_PEND, 16'h0001);
        apb_read(A_PEND, r);
        total++; if (r !== 16'h0000) $display("FAIL w1c_plain: got %h want 0000", r); else passed++;
        ints[0] = 1'b1;
        tick();
        ints[0] = 1'b0;
        tick();
        // W1C access edge coincides with a new rise on line 0
        paddr = BW'(A_PEND); pwdata = 16'h0001; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        ints[0] = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        ints[0] = 1'b0;
        apb_read(A_PEND, r);
        total++; if (r !== 16'h0001) $display("FAIL w1c_vs_rise: got %h want 0001", r); else passed++;
    endtask

    task automatic test_reset_midop();
        logic [DW-1:0] r;
        apb_write(A_MASK, 16'h0003);
        ints_data[0*DW +: DW] = 16'h7777;
        ints[1:0] = 2'b11;
        tick();
        ints[1:0] = 2'b00;
        tick();
        apb_read(A_PEND, r);
        total++; if (r !== 16'h0003) $display("FAIL pre_reset_pend: got %h want 0003", r); else passed++;
        total++; if (irq !== 1'b1) $display("FAIL pre_reset_irq: got %b want 1", irq); else passed++;
        reset = 1'b1;
        irq_ack = 1'b1;
        tick();
        reset = 1'b0;
        irq_ack = 1'b0;
        total++; if (irq !== 1'b0) $display("FAIL midreset_irq: got %b want 0", irq); else passed++;
        total++; if (irq_data !== 16'h0) $display("FAIL midreset_data: got %h want 0000", irq_data); else passed++;
        total++; if (irq_vec !== 3'd0) $display("FAIL midreset_vec: got %h want 0", irq_vec); else passed++;
        apb_read(A_PEND, r);
        total++; if (r !== 16'h0000) $display("FAIL midreset_pend: got %h want 0000", r); else passed++;
        apb_read(A_MASK, r);
        total++; if (r !== 16'h0000) $display("FAIL midreset_mask: got %h want 0000", r); else passed++;
        apb_read(A_CTRL, r);
        total++; if (r !== 16'h0000) $display("FAIL midreset_ctrl: got %h want 0000", r); else passed++;
    endtask

    initial begin
        test_reset();
        test_regs();
        test_single();
        test_priority();
        test_mask();
        test_w1c_vs_rise();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
